// File: rtl/key10_debounce.sv
// key10_debounce: synchronizes and debounces a 10-key one-hot keypad.
// A single key must be seen stable for DEBOUNCE_CYCLES samples after its first
// synchronized sample before it is accepted. Release is debounced the same way.
// Multi-key vectors are never accepted; o_multi flags them.
module key10_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_key,
  output logic [9:0] o_data,
  output logic       o_valid,
  output logic       o_multi
);

  localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StConfirm, StHold, StRelease} state_e;

  state_e      r_state, w_state_nxt;
  logic [9:0]  r_key_m, r_key_s;
  logic [9:0]  r_cand, w_cand_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [9:0]  r_data, w_data_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_multi;

  logic        w_nonzero;
  logic        w_onehot;
  logic        w_multi;

  assign w_nonzero = (r_key_s != 10'd0);
  assign w_onehot  = w_nonzero && ((r_key_s & (r_key_s - 10'd1)) == 10'd0);
  assign w_multi   = w_nonzero && !w_onehot;

  // Two-flop synchronizer for the asynchronous key levels.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key_m <= 10'd0;
      r_key_s <= 10'd0;
    end else begin
      r_key_m <= i_key;
      r_key_s <= r_key_m;
    end
  end

  // Next-state and registered-output decisions, all based on r_key_s.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_onehot) begin
          w_cand_nxt  = r_key_s;
          w_cnt_nxt   = 16'd0;
          w_state_nxt = StConfirm;
        end
      end
      StConfirm: begin
        if (r_key_s == r_cand) begin
          if (r_cnt == CntMax) begin
            w_data_nxt  = r_cand;
            w_valid_nxt = 1'b1;
            w_state_nxt = StHold;
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end else begin
          w_cnt_nxt   = 16'd0;
          w_state_nxt = StIdle;
        end
      end
      StHold: begin
        // Any nonzero pattern, including extra keys, keeps the accepted key.
        if (!w_nonzero) begin
          w_cnt_nxt   = 16'd0;
          w_state_nxt = StRelease;
        end
      end
      StRelease: begin
        if (w_nonzero) begin
          w_cnt_nxt   = 16'd0;
          w_state_nxt = StHold;
        end else if (r_cnt == CntMax) begin
          w_data_nxt  = 10'd0;
          w_cnt_nxt   = 16'd0;
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State, candidate, counter and output registers; reset wins in every state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cand  <= 10'd0;
      r_cnt   <= 16'd0;
      r_data  <= 10'd0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_multi <= w_multi;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_multi = r_multi;

endmodule

// File: doc/key10_debounce.md
KEY10_DEBOUNCE -- requirements
Module: key10_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20, which sets the stable-sample count N (legal 2..65535; internal counter 16 bits wide).
REQ-002 The block SHALL have port i_clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_rst, input, width 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_key, input, width 10: raw asynchronous key levels, active-high, bit k = key k.
REQ-005 The block SHALL have port o_data, output, width 10: debounced one-hot key vector (all-zero = no key), driving i_data of the downstream 10-to-4 encoder.
REQ-006 The block SHALL have port o_valid, output, width 1: one-cycle pulse marking a newly accepted key press.
REQ-007 The block SHALL have port o_multi, output, width 1: registered level, high while the synchronized key vector has more than one bit set.

Function
REQ-008 i_key SHALL pass through a 2-flop synchronizer (r_key_s); all decisions SHALL use r_key_s only.
REQ-009 The FSM SHALL have four states: IDLE, CONFIRM, HOLD and RELEASE; it SHALL hold a 10-bit candidate register and a counter cnt.
REQ-010 In IDLE with r_key_s exactly one-hot, the FSM SHALL load candidate <= r_key_s and cnt <= 0, and go to CONFIRM.
REQ-011 In IDLE with r_key_s zero or multi-bit, the FSM SHALL stay in IDLE.
REQ-012 In CONFIRM with r_key_s == candidate and cnt < N-1, the FSM SHALL set cnt <= cnt+1.
REQ-013 In CONFIRM with r_key_s == candidate and cnt == N-1, the FSM SHALL go to HOLD, set o_data <= candidate and pulse o_valid for exactly 1 cycle.
REQ-014 In CONFIRM with r_key_s != candidate (including zero or multi-bit), the FSM SHALL return to IDLE with cnt <= 0 and no o_valid.
REQ-015 In HOLD, o_data SHALL stay constant; the FSM SHALL go to RELEASE with cnt <= 0 when r_key_s == 0; any nonzero change, including added keys, SHALL be ignored.
REQ-016 In RELEASE with r_key_s == 0, cnt SHALL increment; at cnt == N-1 the FSM SHALL go to IDLE with o_data <= 0.
REQ-017 In RELEASE with r_key_s != 0, the FSM SHALL return to HOLD with cnt <= 0, o_data unchanged and no o_valid.
REQ-018 Press latency: with i_key stable from edge 1 (first edge sampling the new value), o_valid and the new o_data SHALL appear after edge N+3.
REQ-019 Release latency: o_data SHALL go to 0 after edge N+3 of stable all-zero i_key.
REQ-020 o_valid SHALL be high only in the cycle o_data first shows a newly accepted key; at most one o_valid per press-release cycle.
REQ-021 o_data SHALL always be zero or exactly one-hot.
REQ-022 o_multi SHALL equal (popcount(r_key_s) > 1), registered one cycle after r_key_s, in every state.
REQ-023 A multi-key vector SHALL never be accepted.
REQ-024 If a second key is added while in HOLD, o_multi SHALL go high, o_data SHALL keep the original key and no o_valid SHALL be generated.

Reset
REQ-025 While i_rst is high at a rising edge: o_data=0, o_valid=0, o_multi=0, both synchronizer stages=0, candidate=0, cnt=0, state=IDLE.
REQ-026 Reset SHALL take precedence over all FSM activity in any state.
REQ-027 A key still held when i_rst falls SHALL be re-debounced from scratch: o_valid follows N+3 edges after the first post-reset edge.

Verification (N=4)
REQ-028 Clean press: i_key=10'h008 for 20 cycles -> single o_valid after edge 7, o_data=10'h008 (encoder code 3); release -> o_data=0 after edge 7 of zero input.
REQ-029 Bounce: i_key toggles 0/10'h020 every 2 cycles for 12 cycles, then holds 10'h020 -> no o_valid during bouncing; one o_valid 7 edges after settling, o_data=10'h020.
REQ-030 Multi-key: i_key=10'h003 held 10 cycles -> o_multi=1 from edge 3, o_valid never asserted, o_data=0.
REQ-031 Release glitch: in HOLD on 10'h001, i_key=0 for 2 cycles then back to 10'h001 -> o_data stays 10'h001, no o_valid; then full release -> o_data=0 after 7 edges.
REQ-032 Reset mid-HOLD: i_rst=1 for 1 cycle while 10'h200 is held -> next edge o_data=0; key still held -> new o_valid 7 edges after i_rst falls, o_data=10'h200.
REQ-033 Walk: press and release keys 0..9 in turn (10 cycles each, 10-cycle gaps) -> exactly 10 o_valid pulses, o_data = 1<<k on each, encoder codes 0..9.
